amp_gain_ctrl: RTL and testbench

- Clocked controller that sequences and configures the wreal gain stage (enable + 2-bit gain word, gain = factor*code).
- Powers the amplifier up only once the supply is good and waits a settle time.
- Then runs a windowed automatic gain control loop on the amplifier output, stepping the gain code to keep |out| inside a target band.
- Sits between the digital control domain and the amplifier instance; drives its `en` and `amp` pins.

---
 rtl/amp_gain_ctrl.sv | 142 ++++++++++++++
 tb/tb_amp_gain_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/amp_gain_ctrl.sv
// Power-up sequencer and windowed AGC for a wreal gain stage.
// Drives the amplifier enable and 2-bit gain code from supply and output feedback.
module amp_gain_ctrl #(
  parameter int         SETTLE_CYC = 16,
  parameter int         DWELL_CYC  = 32,
  parameter logic [1:0] INIT_CODE  = 2'd1,
  parameter logic [1:0] MIN_CODE   = 2'd1,
  parameter real        VDD_OK     = 0.9,
  parameter real        HI_TH      = 0.8,
  parameter real        LO_TH      = 0.2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  real        vdd,
  input  real        sig,
  output logic       en,
  output logic [1:0] amp,
  output logic       locked,
  output logic       uv_fault
);

  localparam int CW = $clog2(SETTLE_CYC + 1);
  localparam int WW = $clog2(DWELL_CYC + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, TRACK} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] win_q, win_d;
  logic          over_q, over_d;
  logic          weak_q, weak_d;
  logic          en_d, locked_d, uv_d;
  logic [1:0]    amp_d;

  real  sig_abs;
  logic vdd_ok, sig_over, sig_weak, over_acc, weak_acc;

  // A NaN on either analog input makes every comparison false: not ok, not over, not weak.
  always_comb begin
    sig_abs  = (sig < 0.0) ? -sig : sig;
    vdd_ok   = (vdd > VDD_OK);
    sig_over = (sig_abs > HI_TH);
    sig_weak = (sig_abs < LO_TH);
    over_acc = over_q | sig_over;
    weak_acc = weak_q & sig_weak;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      win_q    <= '0;
      over_q   <= 1'b0;
      weak_q   <= 1'b0;
      en       <= 1'b0;
      amp      <= 2'b00;
      locked   <= 1'b0;
      uv_fault <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      win_q    <= win_d;
      over_q   <= over_d;
      weak_q   <= weak_d;
      en       <= en_d;
      amp      <= amp_d;
      locked   <= locked_d;
      uv_fault <= uv_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    win_d    = win_q;
    over_d   = over_q;
    weak_d   = weak_q;
    en_d     = en;
    amp_d    = amp;
    locked_d = locked;
    uv_d     = uv_fault;

    case (state_q)
      IDLE: begin
        en_d     = 1'b0;
        amp_d    = 2'b00;
        locked_d = 1'b0;
        if (!start) begin
          uv_d = 1'b0;
        end else if (vdd_ok && !uv_fault) begin
          state_d = SETTLE;
          cnt_d   = CW'(SETTLE_CYC - 1);
          amp_d   = INIT_CODE;
          en_d    = 1'b1;
        end
      end

      SETTLE, TRACK: begin
        // Supply loss outranks a dropped start so the fault is never missed.
        if (!vdd_ok || !start) begin
          state_d  = IDLE;
          en_d     = 1'b0;
          amp_d    = 2'b00;
          locked_d = 1'b0;
          if (!vdd_ok) uv_d = 1'b1;
        end else if (state_q == SETTLE) begin
          if (cnt_q == '0) begin
            state_d = TRACK;
            win_d   = WW'(DWELL_CYC - 1);
            over_d  = 1'b0;
            weak_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end else if (win_q == '0) begin
          if (over_acc && (amp > MIN_CODE)) begin
            amp_d    = amp - 2'd1;
            locked_d = 1'b0;
          end else if (weak_acc && (amp < 2'd3)) begin
            amp_d    = amp + 2'd1;
            locked_d = 1'b0;
          end else begin
            locked_d = 1'b1;
          end
          win_d  = WW'(DWELL_CYC - 1);
          over_d = 1'b0;
          weak_d = 1'b1;
        end else begin
          win_d  = win_q - WW'(1);
          over_d = over_acc;
          weak_d = weak_acc;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_amp_gain_ctrl.sv
// Directed self-checking bench for amp_gain_ctrl (SETTLE_CYC=4, DWELL_CYC=8, INIT_CODE=1).
module tb_amp_gain_ctrl;

  logic       clk;
  logic       rstn;
  logic       start;
  real        vdd;
  real        sig;
  logic       en;
  logic [1:0] amp;
  logic       locked;
  logic       uv_fault;

  int testCount = 0;
  int failCount = 0;

  amp_gain_ctrl #(
    .SETTLE_CYC(4),
    .DWELL_CYC (8),
    .INIT_CODE (2'd1),
    .MIN_CODE  (2'd1)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .vdd     (vdd),
    .sig     (sig),
    .en      (en),
    .amp     (amp),
    .locked  (locked),
    .uv_fault(uv_fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n rising edges and land 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input real v, input real g);
    start = s;
    vdd   = v;
    sig   = g;
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    testCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rstn = 1'b0;
    applyStimulus(1'b0, 0.0, 0.0);
    tick(2);
    checkOutput("rst_en", en, 2'd0);
    checkOutput("rst_amp", amp, 2'd0);
    checkOutput("rst_locked", locked, 2'd0);
    checkOutput("rst_uv", uv_fault, 2'd0);
    rstn = 1'b1;
    tick(1);
    checkOutput("idle_en", en, 2'd0);

    // 1: nominal power-up; first window evaluation 12 cycles after en
    applyStimulus(1'b1, 1.2, 0.5);
    tick(1);
    checkOutput("t1_en", en, 2'd1);
    checkOutput("t1_amp", amp, 2'd1);
    checkOutput("t1_locked0", locked, 2'd0);
    tick(11);
    checkOutput("t1_prelock", locked, 2'd0);
    tick(1);
    checkOutput("t1_locked", locked, 2'd1);
    checkOutput("t1_amp_hold", amp, 2'd1);

    // 2: weak signal steps gain up to saturation
    sig = 0.05;
    tick(7);
    checkOutput("t2_mid_amp", amp, 2'd1);
    tick(1);
    checkOutput("t2_amp2", amp, 2'd2);
    checkOutput("t2_unlock", locked, 2'd0);
    tick(8);
    checkOutput("t2_amp3", amp, 2'd3);
    checkOutput("t2_unlock3", locked, 2'd0);
    tick(8);
    checkOutput("t2_sat_amp", amp, 2'd3);
    checkOutput("t2_sat_locked", locked, 2'd1);

    // 3: single overload sample inside a window steps gain down
    sig = 0.5;
    tick(3);
    sig = -1.5;
    tick(1);
    sig = 0.5;
    tick(4);
    checkOutput("t3_amp2", amp, 2'd2);
    checkOutput("t3_unlock", locked, 2'd0);
    tick(8);
    checkOutput("t3_relock", locked, 2'd1);
    checkOutput("t3_amp_hold", amp, 2'd2);

    // 4: undervoltage while tracking latches a fault and blocks restart
    vdd = 0.8;
    tick(1);
    checkOutput("t4_en", en, 2'd0);
    checkOutput("t4_amp", amp, 2'd0);
    checkOutput("t4_uv", uv_fault, 2'd1);
    checkOutput("t4_locked", locked, 2'd0);
    vdd = 1.2;
    tick(3);
    checkOutput("t4_blocked_en", en, 2'd0);
    checkOutput("t4_uv_sticky", uv_fault, 2'd1);
    start = 1'b0;
    tick(1);
    checkOutput("t4_uv_clear", uv_fault, 2'd0);
    start = 1'b1;
    tick(1);
    checkOutput("t4_restart_en", en, 2'd1);
    checkOutput("t4_restart_amp", amp, 2'd1);

    // 5: supply not yet up is not a fault; start dropped in SETTLE
    start = 1'b0;
    tick(1);
    checkOutput("t5_stop_en", en, 2'd0);
    applyStimulus(1'b1, 0.5, 0.5);
    tick(2);
    checkOutput("t5_lowv_en", en, 2'd0);
    checkOutput("t5_lowv_uv", uv_fault, 2'd0);
    vdd = $bitstoreal(64'h7FF8000000000000);
    tick(2);
    checkOutput("t5_nan_en", en, 2'd0);
    vdd = 0.9;
    tick(2);
    checkOutput("t5_thresh_en", en, 2'd0);
    vdd = 1.0;
    tick(1);
    checkOutput("t5_en", en, 2'd1);
    checkOutput("t5_amp", amp, 2'd1);
    tick(2);
    start = 1'b0;
    tick(1);
    checkOutput("t5_abort_en", en, 2'd0);
    checkOutput("t5_abort_amp", amp, 2'd0);
    checkOutput("t5_abort_uv", uv_fault, 2'd0);

    // 6: async reset mid-cycle while tracking at full gain
    applyStimulus(1'b1, 1.2, 0.05);
    tick(1);
    checkOutput("t6_en", en, 2'd1);
    tick(28);
    checkOutput("t6_amp3", amp, 2'd3);
    checkOutput("t6_locked", locked, 2'd1);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("t6_rst_en", en, 2'd0);
    checkOutput("t6_rst_amp", amp, 2'd0);
    checkOutput("t6_rst_locked", locked, 2'd0);
    start = 1'b0;
    tick(1);
    rstn = 1'b1;
    tick(3);
    checkOutput("t6_idle_en", en, 2'd0);
    checkOutput("t6_idle_uv", uv_fault, 2'd0);
    start = 1'b1;
    tick(1);
    checkOutput("t6_restart_en", en, 2'd1);
    checkOutput("t6_restart_amp", amp, 2'd1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
